// File: rtl/path_node_mc.sv
// path_node_mc: DAG path-counting node with NUM_CH tag-indexed count channels.
// Optional build macro PATH_NODE_SAT_EN selects saturating channel adds.
module path_node_mc #(
    parameter int NUM_CH         = 4,
    parameter int SUM_W          = 64,
    parameter int NODE_ID_W      = 10,
    parameter int MAX_PARENTS    = 32,
    parameter int MAX_CHILDREN   = 32,
    parameter int EDGES_PER_LOAD = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [1:0]                            in_ctrl,
    input  logic [$clog2(MAX_CHILDREN+1)-1:0]     in_num_children,
    input  logic                                  in_is_target,
    input  logic [$clog2(NUM_CH)-1:0]             in_tag,
    input  logic [$clog2(EDGES_PER_LOAD+1)-1:0]   in_num_edges,
    input  logic [EDGES_PER_LOAD*NODE_ID_W-1:0]   in_edges,
    input  logic [NUM_CH*SUM_W-1:0]               in_sum,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [1:0]                            out_ctrl,
    output logic [NODE_ID_W-1:0]                  out_dst,
    output logic [NUM_CH*SUM_W-1:0]               out_sum,
    output logic [2:0]                            err
);
    localparam int TW = $clog2(NUM_CH);
    localparam int PW = $clog2(MAX_PARENTS+1);
    localparam int PI = $clog2(MAX_PARENTS);
    localparam int CW = $clog2(MAX_CHILDREN+1);
    localparam int XW = SUM_W + TW + 1;

    localparam logic [1:0] C_CFG  = 2'd0;
    localparam logic [1:0] C_PAR  = 2'd1;
    localparam logic [1:0] C_SUM  = 2'd2;
    localparam logic [1:0] C_DONE = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE, S_COLLECT, S_SEND, S_DONE
    } state_e;

    state_e                                 state_q, state_d;
    logic [NUM_CH-1:0][SUM_W-1:0]           acc_q, acc_d, acc_add;
    logic [TW-1:0]                          tag_q, tag_d;
    logic [CW-1:0]                          pend_q, pend_d;
    logic [PW-1:0]                          np_q, np_d;
    logic                                   tgt_q, tgt_d;
    logic [2:0]                             err_q, err_d;
    logic [MAX_PARENTS-1:0][NODE_ID_W-1:0]  par_q, par_d;
    logic                                   out_valid_q, out_valid_d;
    logic [1:0]                             out_ctrl_q, out_ctrl_d;
    logic [NODE_ID_W-1:0]                   out_dst_q, out_dst_d;
    logic [NUM_CH*SUM_W-1:0]                out_sum_q, out_sum_d;
    logic                                   ovf;
    logic                                   fire;

    assign out_valid = out_valid_q;
    assign out_ctrl  = out_ctrl_q;
    assign out_dst   = out_dst_q;
    assign out_sum   = out_sum_q;
    assign err       = err_q;
    assign fire      = in_valid && in_ready;

    // Per-channel merge of one SUM packet: gather colliding m|tag lanes, then add to acc.
    always_comb begin
        logic [XW-1:0] tot;
        ovf     = 1'b0;
        acc_add = acc_q;
        for (int c = 0; c < NUM_CH; c++) begin
            tot = XW'(acc_q[c]);
            for (int m = 0; m < NUM_CH; m++) begin
                if ((TW'(m) | tag_q) == TW'(c))
                    tot = tot + XW'(in_sum[m*SUM_W +: SUM_W]);
            end
            acc_add[c] = tot[SUM_W-1:0];
            if (tot[XW-1:SUM_W] != '0) begin
                ovf = 1'b1;
`ifdef PATH_NODE_SAT_EN
                acc_add[c] = '1;
`else
                acc_add[c] = tot[SUM_W-1:0];
`endif
            end
        end
    end

    // Next-state, handshake and output-register loading for the node FSM.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        tag_d       = tag_q;
        pend_d      = pend_q;
        np_d        = np_q;
        tgt_d       = tgt_q;
        err_d       = err_q;
        par_d       = par_q;
        out_valid_d = out_valid_q;
        out_ctrl_d  = out_ctrl_q;
        out_dst_d   = out_dst_q;
        out_sum_d   = out_sum_q;
        in_ready    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                in_ready = (in_ctrl != C_SUM);
                if (fire) begin
                    case (in_ctrl)
                        C_PAR: begin
                            for (int i = 0; i < EDGES_PER_LOAD; i++) begin
                                if (i < int'(in_num_edges)) begin
                                    if (int'(np_d) < MAX_PARENTS) begin
                                        par_d[np_d[PI-1:0]] =
                                            in_edges[i*NODE_ID_W +: NODE_ID_W];
                                        np_d = np_d + PW'(1);
                                    end else begin
                                        err_d[1] = 1'b1;
                                    end
                                end
                            end
                        end
                        C_CFG: begin
                            tag_d  = in_tag;
                            tgt_d  = in_is_target;
                            pend_d = in_num_children;
                            if (in_num_children == '0) begin
                                acc_d[in_tag] = SUM_W'(1);
                                state_d       = S_SEND;
                            end else begin
                                state_d = S_COLLECT;
                            end
                        end
                        default: err_d[2] = 1'b1;
                    endcase
                end
            end
            S_COLLECT: begin
                in_ready = 1'b1;
                if (fire) begin
                    if (in_ctrl == C_SUM) begin
                        acc_d    = acc_add;
                        err_d[0] = err_q[0] | ovf;
                        pend_d   = pend_q - CW'(1);
                        if (pend_q == CW'(1))
                            state_d = S_SEND;
                    end else begin
                        err_d[2] = 1'b1;
                    end
                end
            end
            S_SEND: begin
                if (!out_valid_q) begin
                    if (tgt_q) begin
                        out_valid_d = 1'b1;
                        out_ctrl_d  = C_DONE;
                        out_dst_d   = '0;
                        out_sum_d   = acc_q;
                    end else if (np_q != '0) begin
                        out_valid_d = 1'b1;
                        out_ctrl_d  = C_SUM;
                        out_dst_d   = par_q[PI'(np_q - PW'(1))];
                        out_sum_d   = acc_q;
                    end else begin
                        state_d = S_DONE;
                    end
                end else if (out_ready) begin
                    if (tgt_q) begin
                        out_valid_d = 1'b0;
                        state_d     = S_DONE;
                    end else if (np_q == PW'(1)) begin
                        out_valid_d = 1'b0;
                        np_d        = '0;
                        state_d     = S_DONE;
                    end else begin
                        np_d      = np_q - PW'(1);
                        out_dst_d = par_q[PI'(np_q - PW'(2))];
                    end
                end
            end
            S_DONE: begin
                in_ready    = 1'b1;
                out_valid_d = 1'b0;
                if (fire)
                    err_d[2] = 1'b1;
            end
        endcase
    end

    // State and output registers; reset aborts everything, including the parent table.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            tag_q       <= '0;
            pend_q      <= '0;
            np_q        <= '0;
            tgt_q       <= 1'b0;
            err_q       <= '0;
            par_q       <= '0;
            out_valid_q <= 1'b0;
            out_ctrl_q  <= '0;
            out_dst_q   <= '0;
            out_sum_q   <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            tag_q       <= tag_d;
            pend_q      <= pend_d;
            np_q        <= np_d;
            tgt_q       <= tgt_d;
            err_q       <= err_d;
            par_q       <= par_d;
            out_valid_q <= out_valid_d;
            out_ctrl_q  <= out_ctrl_d;
            out_dst_q   <= out_dst_d;
            out_sum_q   <= out_sum_d;
        end
    end

endmodule

// File: tb/tb_path_node_mc.sv
// tb_path_node_mc: scoreboard bench for path_node_mc (SUM_W=8 build).
// Expected packets are queued at stimulus time and popped on output handshakes.
module tb_path_node_mc;
    localparam int SW = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_ctrl = '0;
    logic [5:0]  in_num_children = '0;
    logic        in_is_target = 1'b0;
    logic [1:0]  in_tag = '0;
    logic [2:0]  in_num_edges = '0;
    logic [39:0] in_edges = '0;
    logic [31:0] in_sum = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [1:0]  out_ctrl;
    logic [9:0]  out_dst;
    logic [31:0] out_sum;
    logic [2:0]  err;

    typedef struct packed {
        logic [1:0]  c;
        logic [9:0]  d;
        logic [31:0] s;
    } pkt_t;

    pkt_t exp_q[$];
    pkt_t e;
    int   n_tests = 0;
    int   n_fail = 0;

    path_node_mc #(.SUM_W(SW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_num_children(in_num_children),
        .in_is_target(in_is_target), .in_tag(in_tag),
        .in_num_edges(in_num_edges), .in_edges(in_edges),
        .in_sum(in_sum), .out_valid(out_valid),
        .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_dst(out_dst), .out_sum(out_sum), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [7:0] a0, input logic [7:0] a1,
                                       input logic [7:0] a2, input logic [7:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    function automatic pkt_t pk(input logic [1:0] c, input logic [9:0] d,
                                input logic [31:0] s);
        pkt_t p;
        p.c = c;
        p.d = d;
        p.s = s;
        return p;
    endfunction

    // Scoreboard: compare every accepted output packet with the queue head.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pkt", {out_ctrl, out_dst}, 0);
            end else begin
                e = exp_q.pop_front();
                check("pkt_ctrl", out_ctrl, e.c);
                check("pkt_dst", out_dst, e.d);
                check("pkt_sum", out_sum, e.s);
            end
        end
    end

    task automatic send(input logic [1:0] c, input logic [5:0] nch,
                        input logic tgt, input logic [1:0] tg,
                        input logic [2:0] ne, input logic [39:0] ed,
                        input logic [31:0] sm);
        int n = 0;
        in_ctrl = c;
        in_num_children = nch;
        in_is_target = tgt;
        in_tag = tg;
        in_num_edges = ne;
        in_edges = ed;
        in_sum = sm;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) check("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic par(input logic [2:0] ne, input logic [39:0] ed);
        send(2'd1, 6'd0, 1'b0, 2'd0, ne, ed, 32'd0);
    endtask

    task automatic cfg(input logic [5:0] nch, input logic tgt, input logic [1:0] tg);
        send(2'd0, nch, tgt, tg, 3'd0, 40'd0, 32'd0);
    endtask

    task automatic sum(input logic [31:0] sm);
        send(2'd2, 6'd0, 1'b0, 2'd0, 3'd0, 40'd0, sm);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
        check("idle_after", out_valid, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ov();
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("wait_out_valid", out_valid, 1);
    endtask

    task automatic load35();
        logic [39:0] ed;
        for (int k = 0; k < 9; k++) begin
            for (int s = 0; s < 4; s++)
                ed[s*10 +: 10] = 10'(4 * k + s + 1);
            par((k == 8) ? 3'd3 : 3'd4, ed);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ovf_exp;
        // 1: leaf with two parents
        do_reset();
        in_ctrl = 2'd0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_ctrl", out_ctrl, 0);
        check("rst_out_dst", out_dst, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_err", err, 0);
        check("rst_in_ready_cfg", in_ready, 1);
        out_ready = 1'b1;
        exp_q.push_back(pk(2'd2, 10'd9, mk(1, 0, 0, 0)));
        exp_q.push_back(pk(2'd2, 10'd5, mk(1, 0, 0, 0)));
        par(3'd2, {20'd0, 10'd9, 10'd5});
        cfg(6'd0, 1'b0, 2'd0);
        drain();
        check("leaf_err", err, 0);

        // 2: tag 2, two children, colliding channels
        do_reset();
        out_ready = 1'b1;
        par(3'd1, {30'd0, 10'd7});
        cfg(6'd2, 1'b0, 2'd2);
        exp_q.push_back(pk(2'd2, 10'd7, mk(0, 0, 12, 1)));
        sum(mk(3, 1, 0, 0));
        sum(mk(4, 0, 5, 0));
        drain();
        check("tag_err", err, 0);

        // 3: backpressure on the first packet
        do_reset();
        out_ready = 1'b0;
        exp_q.push_back(pk(2'd2, 10'd9, mk(1, 0, 0, 0)));
        exp_q.push_back(pk(2'd2, 10'd5, mk(1, 0, 0, 0)));
        par(3'd2, {20'd0, 10'd9, 10'd5});
        cfg(6'd0, 1'b0, 2'd0);
        wait_ov();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", out_valid, 1);
            check("stall_dst", out_dst, 9);
            check("stall_sum", out_sum, mk(1, 0, 0, 0));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        // 4: target node, SUM before CONFIG stalls, late SUM flags err[2]
        do_reset();
        out_ready = 1'b1;
        in_ctrl = 2'd2;
        in_sum = mk(0, 0, 0, 7);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_sum_stall", in_ready, 0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cfg(6'd1, 1'b1, 2'd0);
        exp_q.push_back(pk(2'd3, 10'd0, mk(0, 0, 0, 7)));
        sum(mk(0, 0, 0, 7));
        drain();
        check("tgt_err0", err, 0);
        sum(mk(0, 0, 0, 1));
        check("late_err", err, 3'b100);
        check("late_no_pkt", out_valid, 0);

        // 5: channel overflow
        do_reset();
        out_ready = 1'b1;
`ifdef PATH_NODE_SAT_EN
        ovf_exp = 8'd255;
`else
        ovf_exp = 8'd44;
`endif
        par(3'd1, {30'd0, 10'd1});
        cfg(6'd2, 1'b0, 2'd0);
        exp_q.push_back(pk(2'd2, 10'd1, mk(ovf_exp, 0, 0, 0)));
        sum(mk(200, 0, 0, 0));
        sum(mk(100, 0, 0, 0));
        drain();
        check("ovf_err", err, 3'b001);

        // 6a: 35 parents into a 32-entry table
        do_reset();
        out_ready = 1'b1;
        load35();
        check("ptab_err", err, 3'b010);
        for (int d = 32; d >= 1; d--)
            exp_q.push_back(pk(2'd2, 10'(d), mk(0, 1, 0, 0)));
        cfg(6'd0, 1'b0, 2'd1);
        drain();
        check("ptab_err_end", err, 3'b010);

        // 6b: reset in the middle of SEND
        do_reset();
        out_ready = 1'b0;
        load35();
        cfg(6'd0, 1'b0, 2'd1);
        wait_ov();
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_dst", out_dst, 0);
        check("mid_rst_sum", out_sum, 0);
        in_ctrl = 2'd2;
        in_valid = 1'b1;
        #1;
        check("mid_rst_idle", in_ready, 0);
        in_valid = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_valid", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
